// File: rtl/pmod_ad1_reader.sv
`default_nettype none
// ============================================================================
// Module      : pmod_ad1_reader
// Description : Dual-channel reader for the Digilent PmodAD1 (two AD7476A
//               12-bit ADCs sharing sclk and nCS). A start request runs one
//               16-bit serial frame: chip-select setup, 16 sclk periods with
//               both data lines sampled MSB first, a quiet gap with nCS
//               high, then a one-cycle done pulse as the results update.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_DIV    clk cycles per sclk half-period (legal range 1..255)
// Ports
//   clk        in   system clock, the only clock
//   resetn     in   asynchronous active-low reset
//   start      in   conversion request, sampled while idle
//   sdata0     in   serial data from ADC channel 0
//   sdata1     in   serial data from ADC channel 1
//   sclk       out  serial clock to both ADCs, idle high
//   nCS        out  active-low chip select shared by both ADCs
//   data0      out  last channel-0 result (12 bits)
//   data1      out  last channel-1 result (12 bits)
//   busy       out  high from start acceptance through the done pulse
//   done       out  one-cycle pulse when data0/data1/frame_err update
//   frame_err  out  a leading (must-be-zero) bit of the last frame was 1
// ============================================================================
module pmod_ad1_reader #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        sdata0,
    input  logic        sdata1,
    output logic        sclk,
    output logic        nCS,
    output logic [11:0] data0,
    output logic [11:0] data1,
    output logic        busy,
    output logic        done,
    output logic        frame_err
);

    // Terminal counts for the phase counter. The quiet gap is two
    // half-periods long, so the counter needs 9 bits at CLK_DIV=255.
    localparam logic [8:0] c_HALF_LAST  = 9'(CLK_DIV - 1);
    localparam logic [8:0] c_QUIET_LAST = 9'((2 * CLK_DIV) - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CS_SETUP = 3'd1,
        S_SHIFT    = 3'd2,
        S_QUIET    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [8:0]  r_div_cnt;
    logic [8:0]  w_div_cnt_next;
    logic [3:0]  r_bit_cnt;
    logic [3:0]  w_bit_cnt_next;
    logic        w_half_done;

    logic [1:0]  r_rst_sync;

    logic        r_sclk;
    logic        w_sclk_next;
    logic        r_ncs;
    logic        w_ncs_next;
    logic        r_busy;
    logic        w_busy_next;
    logic        r_done;
    logic        w_done_next;

    logic        w_sample;
    logic        w_load;

    logic [15:0] r_shift0;
    logic [15:0] r_shift1;
    logic [11:0] r_data0;
    logic [11:0] r_data1;
    logic        r_frame_err;

    assign w_half_done = (r_div_cnt == c_HALF_LAST);

    // ------------------------------------------------------------------------
    // Reset release synchroniser. Assertion is asynchronous everywhere; the
    // deassertion is only trusted once it has passed two flops, and the FSM
    // will not leave IDLE before that.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output decode. Every output is computed here for
    // the state being entered and then registered, so the ports carry no
    // combinational path from any input.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_div_cnt_next = r_div_cnt;
        w_bit_cnt_next = r_bit_cnt;
        w_sclk_next    = 1'b1;
        w_ncs_next     = 1'b1;
        w_busy_next    = 1'b1;
        w_done_next    = 1'b0;
        w_sample       = 1'b0;
        w_load         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_div_cnt_next = '0;
                w_bit_cnt_next = '0;
                w_busy_next    = 1'b0;
                if (start && r_rst_sync[1]) begin
                    w_state_next = S_CS_SETUP;
                    w_ncs_next   = 1'b0;
                    w_busy_next  = 1'b1;
                end
            end

            S_CS_SETUP: begin
                w_ncs_next = 1'b0;
                if (w_half_done) begin
                    // First falling sclk edge coincides with SHIFT entry.
                    w_state_next   = S_SHIFT;
                    w_div_cnt_next = '0;
                    w_sclk_next    = 1'b0;
                end else begin
                    w_div_cnt_next = r_div_cnt + 9'd1;
                end
            end

            S_SHIFT: begin
                w_ncs_next  = 1'b0;
                w_sclk_next = r_sclk;
                if (!w_half_done) begin
                    w_div_cnt_next = r_div_cnt + 9'd1;
                end else begin
                    w_div_cnt_next = '0;
                    if (!r_sclk) begin
                        // End of the low half: raise sclk and capture a bit.
                        w_sclk_next    = 1'b1;
                        w_sample       = 1'b1;
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end else if (r_bit_cnt == 4'd0) begin
                        // The counter only reads zero at the end of a high
                        // half after it has wrapped, i.e. after the 16th
                        // sample; the final high half is complete.
                        w_state_next = S_QUIET;
                        w_ncs_next   = 1'b1;
                        w_sclk_next  = 1'b1;
                    end else begin
                        w_sclk_next = 1'b0;
                    end
                end
            end

            S_QUIET: begin
                if (r_div_cnt == c_QUIET_LAST) begin
                    w_state_next   = S_DONE;
                    w_div_cnt_next = '0;
                    w_done_next    = 1'b1;
                    w_load         = 1'b1;
                end else begin
                    w_div_cnt_next = r_div_cnt + 9'd1;
                end
            end

            S_DONE: begin
                // Always pass through IDLE so a held start leaves exactly
                // one idle cycle between frames.
                w_state_next   = S_IDLE;
                w_div_cnt_next = '0;
                w_bit_cnt_next = '0;
                w_busy_next    = 1'b0;
            end

            default: begin
                w_state_next   = S_IDLE;
                w_div_cnt_next = '0;
                w_bit_cnt_next = '0;
                w_busy_next    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counters and handshake outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b1;
            r_ncs     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_div_cnt <= w_div_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_sclk    <= w_sclk_next;
            r_ncs     <= w_ncs_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    // ------------------------------------------------------------------------
    // Serial capture. Both ADCs shift out on the falling sclk edge, so the
    // data lines have been stable for a full half-period when sampled here.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift0 <= '0;
            r_shift1 <= '0;
        end else if (w_sample) begin
            r_shift0 <= {r_shift0[14:0], sdata0};
            r_shift1 <= {r_shift1[14:0], sdata1};
        end
    end

    // ------------------------------------------------------------------------
    // Result registers: updated only on entry to DONE, held otherwise. The
    // AD7476A sends four leading zeros; any 1 there marks a bad frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data0     <= '0;
            r_data1     <= '0;
            r_frame_err <= 1'b0;
        end else if (w_load) begin
            r_data0     <= r_shift0[11:0];
            r_data1     <= r_shift1[11:0];
            r_frame_err <= (|r_shift0[15:12]) | (|r_shift1[15:12]);
        end
    end

    assign sclk      = r_sclk;
    assign nCS       = r_ncs;
    assign busy      = r_busy;
    assign done      = r_done;
    assign data0     = r_data0;
    assign data1     = r_data1;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: doc/pmod_ad1_reader.md
PMOD_AD1_READER -- requirements
Module: pmod_ad1_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, number of clk cycles per sclk half-period (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock (50 MHz), the only clock.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  conversion request, sampled on rising clk edge while idle.
REQ-005 SHALL have port sdata0  input  1  serial data from ADC channel 0.
REQ-006 SHALL have port sdata1  input  1  serial data from ADC channel 1.
REQ-007 SHALL have port sclk  output  1  serial clock to both ADCs, idle high.
REQ-008 SHALL have port nCS  output  1  active-low chip select shared by both ADCs.
REQ-009 SHALL have port data0  output  12  last channel-0 result.
REQ-010 SHALL have port data1  output  12  last channel-1 result.
REQ-011 SHALL have port busy  output  1  high from start acceptance until done pulse inclusive.
REQ-012 SHALL have port done  output  1  one-cycle pulse when data0/data1 are updated.
REQ-013 SHALL have port frame_err  output  1  high if any leading bit of the last frame was 1.

Function
REQ-014 SHALL drive all outputs from registers; no combinational path from inputs to outputs.
REQ-015 SHALL implement states IDLE, CS_SETUP, SHIFT, QUIET, DONE; any other encoding returns to IDLE.
REQ-016 IDLE: nCS=1, sclk=1, busy=0; start=1 at a clk edge -> CS_SETUP, nCS=0 and busy=1 from that edge.
REQ-017 CS_SETUP: hold nCS=0, sclk=1 for CLK_DIV cycles, then -> SHIFT.
REQ-018 SHIFT: generate exactly 16 sclk periods, each CLK_DIV cycles low followed by CLK_DIV cycles high, first falling edge at SHIFT entry.
REQ-019 SHALL sample sdata0/sdata1 into separate 16-bit shift registers, MSB first, on the clk edge that drives sclk from 0 to 1.
REQ-020 SHALL use a 4-bit bit counter; after the 16th sample (counter wrap 15->0) -> QUIET with nCS=1, sclk=1.
REQ-021 QUIET: hold nCS=1 for 2*CLK_DIV cycles, then -> DONE.
REQ-022 DONE: load data0/data1 from shift bits [11:0], load frame_err = OR of bits [15:12] of both channels, done=1 for exactly one cycle, -> IDLE.
REQ-023 Latency: done high exactly 35*CLK_DIV clk cycles after the edge that accepted start.
REQ-024 start while busy=1 SHALL be ignored; no queuing.
REQ-025 start held continuously high SHALL yield back-to-back frames with exactly one IDLE cycle between DONE and next CS_SETUP.
REQ-026 data0, data1, frame_err SHALL hold their values between DONE pulses.
REQ-027 nCS SHALL never be low while sclk is idle outside CS_SETUP/SHIFT; sclk SHALL only toggle while nCS=0.

Reset
REQ-028 resetn=0 SHALL immediately (asynchronously) force state=IDLE, nCS=1, sclk=1, busy=0, done=0, frame_err=0, data0=0, data1=0, bit counter=0, shift registers=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame without a done pulse; first frame after release starts only on a new start.
REQ-030 Release of resetn SHALL be synchronised internally (two-flop) before leaving IDLE.

Verification
REQ-031 CLK_DIV=2, ADC model frames ch0=0x0ABC, ch1=0x0123, one start pulse -> data0=0xABC, data1=0x123, frame_err=0, done 70 cycles after start edge.
REQ-032 CLK_DIV=2, ch0 frame 0x8FFF -> data0=0xFFF, frame_err=1; next clean frame -> frame_err=0.
REQ-033 Count sclk rising edges while nCS=0 per frame -> exactly 16; nCS high ≥4 cycles between frames; sclk constant while nCS=1.
REQ-034 start held high for 3 frames -> 3 done pulses, one IDLE cycle between frames, busy low only in those cycles.
REQ-035 resetn pulsed low at bit 7 of SHIFT -> all outputs at reset values in same cycle, no done, clean frame after next start.
REQ-036 start pulsed during SHIFT and QUIET -> ignored; single done, data unchanged from expected frame.
